router_ctrl_n: RTL and testbench

Parametrised control FSM for the 1-to-N packet router. It sits between the input register/parity block and the per-port output FIFOs. It decodes the header byte, selects and latches the destination port, and sequences header, payload and parity loading. It also handles FIFO-full stalls and per-port soft resets. Compared with the 3-port controller, it generalises to `NUM_PORTS` outputs, discards packets with an out-of-range address, waits in decode when no packet is present, and checks payload length against the header length field.

---
 rtl/router_ctrl_n.sv | 133 +++++++++++++
 tb/tb_router_ctrl_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_ctrl_n.sv
// Control FSM for the 1-to-N packet router: header decode, port latch,
// load sequencing, FIFO-full stalls, per-port soft reset and length check.
module router_ctrl_n #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    din,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_rst,
    input  logic                 low_pkt_valid,
    input  logic                 parity_done,
    output logic                 detect_addr,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 laf_state,
    output logic                 drop_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    port_sel,
    output logic                 len_err
);

    localparam int LEN_W = DATA_W - ADDR_W;
    localparam int NSLOT = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NP = (ADDR_W + 1)'(NUM_PORTS);

    typedef enum logic [3:0] {
        DECODE,
        LOAD_FIRST,
        LOAD_DATA,
        FIFO_FULL,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY,
        WAIT_EMPTY,
        DROP
    } state_t;

    state_t            state, nxt;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  pkt_len;
    logic [ADDR_W-1:0] addr;
    logic [NSLOT-1:0]  empty_pad;
    logic [NSLOT-1:0]  soft_pad;
    logic              addr_bad;
    logic              soft_hit;

    // Pad per-port flags to the full address space so any address indexes safely.
    always_comb begin
        empty_pad = '0;
        soft_pad  = '0;
        empty_pad[NUM_PORTS-1:0] = fifo_empty;
        soft_pad[NUM_PORTS-1:0]  = soft_rst;
    end

    assign addr     = din[ADDR_W-1:0];
    assign addr_bad = {1'b0, addr} >= NP;
    assign soft_hit = soft_pad[port_sel] && (state != DECODE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= DECODE;
            port_sel <= '0;
            pkt_len  <= '0;
            cnt      <= '0;
        end else begin
            state <= nxt;
            if (soft_hit || state == DECODE)
                cnt <= '0;
            else if ((state == LOAD_FIRST || state == LOAD_DATA) && pkt_valid && cnt != '1)
                cnt <= cnt + LEN_W'(1);
            if (state == DECODE && pkt_valid) begin
                port_sel <= addr;
                pkt_len  <= din[DATA_W-1:ADDR_W];
            end
        end
    end

    always_comb begin
        nxt = state;
        if (soft_hit) begin
            nxt = DECODE;
        end else begin
            case (state)
                DECODE: begin
                    if (pkt_valid) begin
                        if (addr_bad)             nxt = DROP;
                        else if (empty_pad[addr]) nxt = LOAD_FIRST;
                        else                      nxt = WAIT_EMPTY;
                    end
                end
                LOAD_FIRST: nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       nxt = FIFO_FULL;
                    else if (!pkt_valid) nxt = LOAD_PARITY;
                end
                FIFO_FULL: if (!fifo_full) nxt = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (parity_done)        nxt = DECODE;
                    else if (low_pkt_valid) nxt = LOAD_PARITY;
                    else                    nxt = LOAD_DATA;
                end
                LOAD_PARITY:  nxt = CHECK_PARITY;
                CHECK_PARITY: nxt = fifo_full ? FIFO_FULL : DECODE;
                WAIT_EMPTY:   if (empty_pad[port_sel]) nxt = LOAD_FIRST;
                DROP:         if (!pkt_valid) nxt = DECODE;
                default:      nxt = DECODE;
            endcase
        end
    end

    // Outputs depend only on registered state, never on inputs.
    always_comb begin
        detect_addr   = (state == DECODE);
        lfd_state     = (state == LOAD_FIRST);
        ld_state      = (state == LOAD_DATA);
        full_state    = (state == FIFO_FULL);
        laf_state     = (state == LOAD_AFTER_FULL);
        drop_state    = (state == DROP);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) || (state == LOAD_PARITY);
        rst_int_reg   = (state == CHECK_PARITY);
        busy          = !((state == DECODE) || (state == LOAD_DATA) || (state == DROP));
        len_err       = (state == CHECK_PARITY) && (cnt != pkt_len);
    end

endmodule

// File: tb/tb_router_ctrl_n.sv
// Bench for router_ctrl_n: directed table, hand-written corner sequences,
// then random traffic against a packet-rule reference model.
module tb_router_ctrl_n;

    localparam int NP = 3;

    localparam int S_DEC = 0, S_LFD = 1, S_LD = 2, S_FF = 3, S_LAF = 4,
                   S_LP = 5, S_CP = 6, S_WE = 7, S_DROP = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          pkt_valid = 1'b0;
    logic [7:0]    din = '0;
    logic          fifo_full = 1'b0;
    logic [NP-1:0] fifo_empty = '1;
    logic [NP-1:0] soft_rst = '0;
    logic          low_pkt_valid = 1'b0;
    logic          parity_done = 1'b0;
    logic detect_addr, lfd_state, ld_state, full_state, laf_state, drop_state;
    logic write_enb_reg, rst_int_reg, busy, len_err;
    logic [1:0] port_sel;

    int n_chk = 0;
    int n_fail = 0;

    int m_st = S_DEC, m_cnt = 0, m_len = 0, m_ps = 0;

    router_ctrl_n #(.NUM_PORTS(NP), .ADDR_W(2), .DATA_W(8)) dut (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .din(din),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_rst(soft_rst),
        .low_pkt_valid(low_pkt_valid), .parity_done(parity_done),
        .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .drop_state(drop_state),
        .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy),
        .port_sel(port_sel), .len_err(len_err)
    );

    always #5 clk = ~clk;

    logic [11:0] act;
    assign act = {detect_addr, lfd_state, ld_state, full_state, laf_state, drop_state,
                  write_enb_reg, rst_int_reg, busy, port_sel, len_err};

    // Expected output word for a given state, port and length-error flag.
    function automatic logic [11:0] dec(int st, logic [1:0] ps, logic le);
        logic we, bsy;
        we  = (st == S_LD) || (st == S_LAF) || (st == S_LP);
        bsy = !((st == S_DEC) || (st == S_LD) || (st == S_DROP));
        return {st == S_DEC, st == S_LFD, st == S_LD, st == S_FF, st == S_LAF,
                st == S_DROP, we, st == S_CP, bsy, ps, le};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: applies the packet rules to the inputs present at this edge.
    task automatic model_step();
        int a, nst;
        if (!rstn) begin
            m_st = S_DEC; m_cnt = 0; m_len = 0; m_ps = 0;
            return;
        end
        if (m_st != S_DEC && m_ps < NP && soft_rst[m_ps]) begin
            m_st = S_DEC; m_cnt = 0;
            return;
        end
        nst = m_st;
        case (m_st)
            S_DEC: if (pkt_valid) begin
                a = int'(din) % 4;
                m_ps = a;
                m_len = int'(din) / 4;
                if (a >= NP)          nst = S_DROP;
                else if (fifo_empty[a]) nst = S_LFD;
                else                  nst = S_WE;
            end
            S_LFD:  nst = S_LD;
            S_LD:   nst = fifo_full ? S_FF : (!pkt_valid ? S_LP : S_LD);
            S_FF:   nst = fifo_full ? S_FF : S_LAF;
            S_LAF:  nst = parity_done ? S_DEC : (low_pkt_valid ? S_LP : S_LD);
            S_LP:   nst = S_CP;
            S_CP:   nst = fifo_full ? S_FF : S_DEC;
            S_WE:   nst = fifo_empty[m_ps] ? S_LFD : S_WE;
            S_DROP: nst = pkt_valid ? S_DROP : S_DEC;
            default: nst = S_DEC;
        endcase
        if (m_st == S_DEC) m_cnt = 0;
        else if ((m_st == S_LFD || m_st == S_LD) && pkt_valid) m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
        m_st = nst;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       pv;
        logic [7:0] d;
        int         st;
        logic [1:0] ps;
        logic       le;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // Good packet to port 1, dropped packet to addr 3, short-header packet to port 0.
        tbl[0]  = '{1'b1, 8'h11, S_LFD, 2'd1, 1'b0};
        tbl[1]  = '{1'b1, 8'hA1, S_LD,  2'd1, 1'b0};
        tbl[2]  = '{1'b1, 8'hA2, S_LD,  2'd1, 1'b0};
        tbl[3]  = '{1'b1, 8'hA3, S_LD,  2'd1, 1'b0};
        tbl[4]  = '{1'b1, 8'hA4, S_LD,  2'd1, 1'b0};
        tbl[5]  = '{1'b0, 8'h5A, S_LP,  2'd1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, S_CP,  2'd1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, S_DEC, 2'd1, 1'b0};
        tbl[8]  = '{1'b1, 8'h0B, S_DROP, 2'd3, 1'b0};
        tbl[9]  = '{1'b1, 8'hB1, S_DROP, 2'd3, 1'b0};
        tbl[10] = '{1'b1, 8'hB2, S_DROP, 2'd3, 1'b0};
        tbl[11] = '{1'b0, 8'hB3, S_DEC,  2'd3, 1'b0};
        tbl[12] = '{1'b1, 8'h0C, S_LFD, 2'd0, 1'b0};
        tbl[13] = '{1'b1, 8'hC1, S_LD,  2'd0, 1'b0};
        tbl[14] = '{1'b1, 8'hC2, S_LD,  2'd0, 1'b0};
        tbl[15] = '{1'b1, 8'hC3, S_LD,  2'd0, 1'b0};
        tbl[16] = '{1'b1, 8'hC4, S_LD,  2'd0, 1'b0};
        tbl[17] = '{1'b1, 8'hC5, S_LD,  2'd0, 1'b0};
        tbl[18] = '{1'b0, 8'h77, S_LP,  2'd0, 1'b0};
        tbl[19] = '{1'b0, 8'h00, S_CP,  2'd0, 1'b1};
        tbl[20] = '{1'b0, 8'h00, S_DEC, 2'd0, 1'b0};

        rstn = 1'b0;
        tick();
        check("reset", dec(S_DEC, 2'd0, 1'b0));
        n_chk++;
        if (dut.cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", dut.cnt);
        end

        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", dec(S_DEC, 2'd0, 1'b0));
        end

        for (int i = 0; i < 21; i++) begin
            pkt_valid = tbl[i].pv;
            din = tbl[i].d;
            tick();
            check($sformatf("table[%0d]", i), dec(tbl[i].st, tbl[i].ps, tbl[i].le));
        end

        // Destination FIFO busy: wait, then load once it drains.
        fifo_empty = 3'b011;
        pkt_valid = 1'b1; din = 8'h02;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            din = 8'hE0;
            check("wait_empty", dec(S_WE, 2'd2, 1'b0));
        end
        fifo_empty = 3'b111;
        tick();
        check("wait_to_lfd", dec(S_LFD, 2'd2, 1'b0));
        pkt_valid = 1'b0;
        tick(); check("we_ld", dec(S_LD, 2'd2, 1'b0));
        tick(); check("we_lp", dec(S_LP, 2'd2, 1'b0));
        tick(); check("we_cp", dec(S_CP, 2'd2, 1'b0));
        tick(); check("we_dec", dec(S_DEC, 2'd2, 1'b0));

        // FIFO-full stall on the second LOAD_DATA cycle, held for 3 samples.
        pkt_valid = 1'b1; din = 8'h11;
        tick(); check("ff_lfd", dec(S_LFD, 2'd1, 1'b0));
        din = 8'hD1;
        tick(); check("ff_ld1", dec(S_LD, 2'd1, 1'b0));
        tick(); check("ff_ld2", dec(S_LD, 2'd1, 1'b0));
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("ff_full", dec(S_FF, 2'd1, 1'b0));
        end
        fifo_full = 1'b0;
        tick(); check("ff_laf", dec(S_LAF, 2'd1, 1'b0));
        tick(); check("ff_ld3", dec(S_LD, 2'd1, 1'b0));
        pkt_valid = 1'b0;
        tick(); check("ff_lp", dec(S_LP, 2'd1, 1'b0));
        tick(); check("ff_cp", dec(S_CP, 2'd1, 1'b1));
        tick(); check("ff_dec", dec(S_DEC, 2'd1, 1'b0));

        // Soft reset: other port ignored, own port aborts and clears the count.
        pkt_valid = 1'b1; din = 8'h0C;
        tick(); check("sr_lfd", dec(S_LFD, 2'd0, 1'b0));
        din = 8'hF1;
        tick(); check("sr_ld", dec(S_LD, 2'd0, 1'b0));
        soft_rst = 3'b010;
        tick(); check("sr_other", dec(S_LD, 2'd0, 1'b0));
        soft_rst = 3'b001;
        tick(); check("sr_own", dec(S_DEC, 2'd0, 1'b0));
        n_chk++;
        if (dut.cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL sr_cnt: got %0d expected 0", dut.cnt);
        end
        soft_rst = 3'b000; pkt_valid = 1'b0;
        tick(); check("sr_idle", dec(S_DEC, 2'd0, 1'b0));

        // Hard reset mid-packet.
        pkt_valid = 1'b1; din = 8'h11;
        tick(); check("rst_lfd", dec(S_LFD, 2'd1, 1'b0));
        rstn = 1'b0;
        tick(); check("rst_mid", dec(S_DEC, 2'd0, 1'b0));
        rstn = 1'b1;

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rstn          = ($urandom_range(0, 199) != 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            din           = 8'($urandom);
            fifo_full     = ($urandom_range(0, 4) == 0);
            for (int p = 0; p < NP; p++) begin
                fifo_empty[p] = ($urandom_range(0, 3) != 0);
                soft_rst[p]   = ($urandom_range(0, 39) == 0);
            end
            low_pkt_valid = ($urandom_range(0, 7) == 0);
            parity_done   = ($urandom_range(0, 7) == 0);
            tick();
            check("random", dec(m_st, 2'(m_ps), (m_st == S_CP) && (m_cnt != m_len)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
